load_store_unit: RTL and testbench

- Memory stage directly downstream of arithmetic_logic_unit in the RV32I core.
- Takes the effective address (ALU result, rs1+imm) and store data (src2_value) for LB/LH/LW/LBU/LHU/SB/SH/SW.
- Drives a single-outstanding request/grant/response data-memory port.
- Returns sign/zero-extended load data plus rd to writeback; flags misaligned, illegal and timed-out accesses.

---
 rtl/riscv_pkg.sv | 39 +++
 rtl/lsu_align.sv | 55 +++++
 rtl/load_store_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I load/store encodings, LSU error codes and LSU state type
// shared by the load/store unit and its lane-alignment helper.
package riscv_pkg;

  // funct3 access size/sign encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // err_code values
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2
  } lsu_state_e;

  function automatic logic f3_is_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (f3)
      F3_H, F3_HU: mis = off[0];
      F3_W:        mis = |off;
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane handling for the load/store unit.
// Stores: replicate the byte/halfword across the word and build the byte strobe.
// Loads: pick the addressed lane out of the read word and sign/zero-extend it.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [1:0]  st_size_i,    // funct3[1:0]: 00 byte, 01 half, else word
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_wstrb_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store lane replication and strobe generation
  always_comb begin
    st_wdata_o = st_data_i;
    st_wstrb_o = 4'b1111;
    case (st_size_i)
      2'b00: begin
        st_wdata_o = {4{st_data_i[7:0]}};
        st_wstrb_o = 4'b0001 << st_off_i;
      end
      2'b01: begin
        st_wdata_o = {2{st_data_i[15:0]}};
        st_wstrb_o = st_off_i[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata_o = st_data_i;
        st_wstrb_o = 4'b1111;
      end
    endcase
  end

  // Load lane extraction and extension
  always_comb begin
    ld_byte   = ld_rdata_i[{ld_off_i, 3'b000} +: 8];
    ld_half   = ld_off_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
    ld_data_o = ld_rdata_i;
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data_o = {24'h000000, ld_byte};
      F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data_o = {16'h0000, ld_half};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory stage behind the ALU. Drives a single-outstanding
// request/grant/response data port, returns extended load data with rd to writeback,
// and reports misaligned, illegal and timed-out accesses as one-cycle error pulses.
// Build option LSU_MISALIGN_CHECK_EN: when defined, misaligned H/HU/W accesses are
// rejected with a misalign error; when undefined the low address bits are ignored.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  input  logic [4:0]        rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              st_done,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic              busy
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  lsu_state_e state_q, state_d;

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        ld_f3_q, ld_f3_d;
  logic [1:0]        ld_off_q, ld_off_d;
  logic [4:0]        rd_q, rd_d;

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              st_done_q, st_done_d;
  logic              err_valid_q, err_valid_d;
  logic [1:0]        err_code_q, err_code_d;

  logic              accept;
  logic              req_illegal;
  logic              req_misalign;
  logic              req_ok;
  logic              timeout_hit;
  logic [31:0]       st_wdata;
  logic [3:0]        st_wstrb;
  logic [31:0]       ld_data;

  assign req_ready   = (state_q == StIdle) && reset;
  assign busy        = (state_q != StIdle);
  assign accept      = req_valid && req_ready;
  assign req_illegal = !f3_is_legal(funct3) || (is_load == is_store);
`ifdef LSU_MISALIGN_CHECK_EN
  assign req_misalign = is_misaligned(funct3, addr[1:0]);
`else
  assign req_misalign = 1'b0;
`endif
  assign req_ok      = accept && !req_illegal && !req_misalign;
  // cnt_q counts cycles already spent in REQ/WAIT; this is the last allowed one
  assign timeout_hit = (cnt_q >= CntLast);

  lsu_align u_align (
    .st_size_i   (funct3[1:0]),
    .st_off_i    (addr[1:0]),
    .st_data_i   (store_data),
    .st_wdata_o  (st_wdata),
    .st_wstrb_o  (st_wstrb),
    .ld_funct3_i (ld_f3_q),
    .ld_off_i    (ld_off_q),
    .ld_rdata_i  (mem_rdata),
    .ld_data_o   (ld_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a completion on the timeout boundary takes priority
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (req_ok) state_d = StReq;
      StReq: begin
        if (mem_gnt) begin
          state_d = mem_we_q ? StIdle : StWait;
        end else if (timeout_hit) begin
          state_d = StIdle;
        end
      end
      StWait: if (mem_rvalid || timeout_hit) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs and latched request fields
  always_comb begin
    cnt_d       = (state_q == StIdle) ? '0 : cnt_q + CntW'(1);
    ld_f3_d     = ld_f3_q;
    ld_off_d    = ld_off_q;
    rd_d        = rd_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    st_done_d   = 1'b0;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    unique case (state_q)
      StIdle: begin
        if (accept && req_illegal) begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_ILLEGAL;
        end else if (accept && req_misalign) begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_MISALIGN;
        end else if (req_ok) begin
          mem_req_d   = 1'b1;
          mem_we_d    = is_store;
          mem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
          mem_wdata_d = st_wdata;
          mem_wstrb_d = is_store ? st_wstrb : 4'b0000;
          ld_f3_d     = funct3;
          ld_off_d    = addr[1:0];
          rd_d        = rd;
        end
      end
      StReq: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          st_done_d = mem_we_q;
        end else if (timeout_hit) begin
          mem_req_d   = 1'b0;
          err_valid_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
        end
      end
      StWait: begin
        if (mem_rvalid) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = ld_data;
        end else if (timeout_hit) begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
        end
      end
      default: begin
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Output and request-field registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q       <= '0;
      ld_f3_q     <= 3'b000;
      ld_off_q    <= 2'b00;
      rd_q        <= 5'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      mem_wstrb_q <= 4'b0000;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 32'h0;
      st_done_q   <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      cnt_q       <= cnt_d;
      ld_f3_q     <= ld_f3_d;
      ld_off_q    <= ld_off_d;
      rd_q        <= rd_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      st_done_q   <= st_done_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign st_done   = st_done_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit. Each scenario pushes its
// expected response when it drives a request and pops/compares when the LSU responds.
module tb_load_store_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic [4:0]  rd = 5'd0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        st_done, err_valid, busy;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  ev;     // {err_valid, st_done, wb_valid}
    int          cyc;    // cycle of the response pulse, accept edge = cycle 0
    logic [31:0] data;
    logic [4:0]  rd;
    logic [1:0]  code;
    logic        req;    // a memory request is expected
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } exp_t;
  exp_t sb_q[$];

  // Observations captured by run_access
  logic [2:0]  ev_seen;
  int          ev_cyc;
  logic [31:0] got_data;
  logic [4:0]  got_rd;
  logic [1:0]  got_code;
  logic        got_req;
  logic        saw_req, seen_we, unstable, rdy_busy;
  int          req_cycles;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_wstrb;

  load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .is_load    (is_load),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .rd         (rd),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .st_done    (st_done),
    .err_valid  (err_valid),
    .err_code   (err_code),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Issue one request at the next edge and act as memory: grant at cycle gnt_at
  // (if mem_req is up), rvalid rv_dly cycles after the grant. Stops at the first
  // response pulse or after 40 cycles.
  task automatic run_access(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                            input int gnt_at, input int rv_dly, input logic [31:0] rdata);
    logic granted;
    int   gnt_cyc;
    saw_req = 0; unstable = 0; rdy_busy = 0; req_cycles = 0;
    ev_seen = 3'b000; ev_cyc = -1; got_data = 32'h0; got_rd = 5'd0; got_code = 2'b00;
    got_req = 1'b0; granted = 1'b0; gnt_cyc = 0;
    seen_addr = 32'h0; seen_wdata = 32'h0; seen_wstrb = 4'h0; seen_we = 1'b0;
    req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a;
    store_data = d; rd = r; mem_rdata = rdata;
    @(posedge clk); #1;
    req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (wb_valid || st_done || err_valid) begin
        ev_seen = {err_valid, st_done, wb_valid}; ev_cyc = n;
        got_data = wb_data; got_rd = wb_rd; got_code = err_code; got_req = mem_req;
        break;
      end
      if (req_ready) rdy_busy = 1'b1;
      if (mem_req) begin
        if (!saw_req) begin
          saw_req = 1'b1; seen_addr = mem_addr; seen_wdata = mem_wdata;
          seen_wstrb = mem_wstrb; seen_we = mem_we;
        end else if (mem_addr !== seen_addr || mem_wdata !== seen_wdata ||
                     mem_wstrb !== seen_wstrb || mem_we !== seen_we) begin
          unstable = 1'b1;
        end
        req_cycles++;
        if (!granted && n >= gnt_at) begin
          mem_gnt = 1'b1; granted = 1'b1; gnt_cyc = n;
        end
      end
      if (ld && granted && !mem_gnt && n == gnt_cyc + rv_dly) mem_rvalid = 1'b1;
      @(posedge clk); #1;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_wstrb !== 4'h0) begin
        errors++; $display("FAIL reset mem ctrl: req=%b we=%b wstrb=%h, want 0", mem_req, mem_we, mem_wstrb); end
      checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
        errors++; $display("FAIL reset mem data: addr=%h wdata=%h, want 0", mem_addr, mem_wdata); end
      checks++; if (wb_valid !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'h0) begin
        errors++; $display("FAIL reset wb: v=%b rd=%0d data=%h, want 0", wb_valid, wb_rd, wb_data); end
      checks++; if (st_done !== 1'b0 || err_valid !== 1'b0 || err_code !== 2'b00) begin
        errors++; $display("FAIL reset flags: st=%b ev=%b ec=%b, want 0", st_done, err_valid, err_code); end
      checks++; if (busy !== 1'b0 || req_ready !== 1'b0) begin
        errors++; $display("FAIL reset busy/ready: busy=%b ready=%b, want 0/0", busy, req_ready); end
    end
    reset = 1'b1; #1;
    checks++; if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset release ready: got %b want 1", req_ready); end
  endtask

  task automatic test_store;
    exp_t e; logic [2:0] f3; logic [31:0] a, d; int g;
    for (int i = 0; i < 4; i++) begin
      e = '{3'b010, 0, 32'h0, 5'd0, 2'b00, 1'b1, 32'h0, 32'h0, 4'h0};
      case (i)
        0: begin f3 = F3_W; a = 32'h100; d = 32'hDEADBEEF; g = 1; e.wdata = 32'hDEADBEEF; e.wstrb = 4'b1111; end
        1: begin f3 = F3_B; a = 32'h103; d = 32'h000000A5; g = 1; e.wdata = 32'hA5A5A5A5; e.wstrb = 4'b1000; end
        2: begin f3 = F3_H; a = 32'h102; d = 32'h1234ABCD; g = 1; e.wdata = 32'hABCDABCD; e.wstrb = 4'b1100; end
        default: begin f3 = F3_B; a = 32'h201; d = 32'hFFFF0077; g = 3; e.wdata = 32'h77777777; e.wstrb = 4'b0010; end
      endcase
      e.cyc = g + 1; e.maddr = {a[31:2], 2'b00};
      sb_q.push_back(e);
      run_access(1'b0, 1'b1, f3, a, d, 5'd0, g, 1, 32'h0);
      e = sb_q.pop_front();
      checks++; if (ev_seen !== e.ev || ev_cyc != e.cyc) begin
        errors++; $display("FAIL store[%0d] response: ev=%b cyc=%0d, want ev=%b cyc=%0d", i, ev_seen, ev_cyc, e.ev, e.cyc); end
      checks++; if (seen_addr !== e.maddr || seen_we !== 1'b1) begin
        errors++; $display("FAIL store[%0d] addr/we: %h/%b, want %h/1", i, seen_addr, seen_we, e.maddr); end
      checks++; if (seen_wdata !== e.wdata || seen_wstrb !== e.wstrb) begin
        errors++; $display("FAIL store[%0d] wdata/wstrb: %h/%b, want %h/%b", i, seen_wdata, seen_wstrb, e.wdata, e.wstrb); end
      checks++; if (rdy_busy !== 1'b0 || unstable !== 1'b0) begin
        errors++; $display("FAIL store[%0d] ready-while-busy=%b unstable=%b, want 0/0", i, rdy_busy, unstable); end
    end
  endtask

  task automatic test_load;
    exp_t e; logic [2:0] f3; logic [31:0] a, w; int g, rv;
    for (int i = 0; i < 7; i++) begin
      e = '{3'b001, 0, 32'h0, 5'd0, 2'b00, 1'b1, 32'h0, 32'h0, 4'h0};
      g = 1; rv = 1; w = 32'h12F45678;
      case (i)
        0: begin f3 = F3_B;  a = 32'h102; e.data = 32'hFFFFFFF4; e.rd = 5'd5; end
        1: begin f3 = F3_BU; a = 32'h102; e.data = 32'h000000F4; e.rd = 5'd6; end
        2: begin f3 = F3_HU; a = 32'h102; e.data = 32'h000012F4; e.rd = 5'd7; end
        3: begin f3 = F3_H;  a = 32'h100; w = 32'h12F48678; e.data = 32'hFFFF8678; e.rd = 5'd8; end
        4: begin f3 = F3_W;  a = 32'h104; w = 32'hCAFEF00D; g = 3; rv = 2; e.data = 32'hCAFEF00D; e.rd = 5'd31; end
        5: begin f3 = F3_B;  a = 32'h101; e.data = 32'h00000056; e.rd = 5'd1; end
        default: begin f3 = F3_BU; a = 32'h103; g = 2; e.data = 32'h00000012; e.rd = 5'd12; end
      endcase
      e.cyc = g + rv + 1; e.maddr = {a[31:2], 2'b00};
      sb_q.push_back(e);
      run_access(1'b1, 1'b0, f3, a, 32'h0, e.rd, g, rv, w);
      e = sb_q.pop_front();
      checks++; if (ev_seen !== e.ev || ev_cyc != e.cyc) begin
        errors++; $display("FAIL load[%0d] response: ev=%b cyc=%0d, want ev=%b cyc=%0d", i, ev_seen, ev_cyc, e.ev, e.cyc); end
      checks++; if (got_data !== e.data || got_rd !== e.rd) begin
        errors++; $display("FAIL load[%0d] wb: data=%h rd=%0d, want %h rd=%0d", i, got_data, got_rd, e.data, e.rd); end
      checks++; if (seen_addr !== e.maddr || seen_we !== 1'b0 || seen_wstrb !== 4'h0) begin
        errors++; $display("FAIL load[%0d] req: addr=%h we=%b wstrb=%b, want %h/0/0000", i, seen_addr, seen_we, seen_wstrb, e.maddr); end
      checks++; if (rdy_busy !== 1'b0) begin
        errors++; $display("FAIL load[%0d] ready while busy: got %b want 0", i, rdy_busy); end
    end
    @(posedge clk); #1;
    checks++; if (wb_valid !== 1'b0) begin
      errors++; $display("FAIL load wb_valid pulse width: got %b want 0", wb_valid); end
  endtask

  task automatic test_misalign;
    exp_t e; logic ld; logic [2:0] f3; logic [31:0] a;
    for (int i = 0; i < 3; i++) begin
      e = '{3'b000, 0, 32'h0, 5'd0, 2'b00, 1'b0, 32'h0, 32'h0, 4'h0};
      case (i)
        0: begin ld = 1'b1; f3 = F3_W; a = 32'h101; e.data = 32'h11223344; end
        1: begin ld = 1'b1; f3 = F3_H; a = 32'h103; e.data = 32'h00001122; end
        default: begin ld = 1'b0; f3 = F3_W; a = 32'h102; end
      endcase
`ifdef LSU_MISALIGN_CHECK_EN
      e.ev = 3'b100; e.cyc = 1; e.code = ERR_MISALIGN;
`else
      e.ev = ld ? 3'b001 : 3'b010; e.cyc = ld ? 3 : 2; e.req = 1'b1; e.maddr = 32'h100;
`endif
      sb_q.push_back(e);
      run_access(ld, !ld, f3, a, 32'hA1B2C3D4, 5'd3, 1, 1, 32'h11223344);
      e = sb_q.pop_front();
      checks++; if (ev_seen !== e.ev || ev_cyc != e.cyc) begin
        errors++; $display("FAIL misalign[%0d] response: ev=%b cyc=%0d, want ev=%b cyc=%0d", i, ev_seen, ev_cyc, e.ev, e.cyc); end
      checks++; if (saw_req !== e.req) begin
        errors++; $display("FAIL misalign[%0d] mem_req seen: got %b want %b", i, saw_req, e.req); end
      if (e.ev[2]) begin
        checks++; if (got_code !== e.code) begin
          errors++; $display("FAIL misalign[%0d] err_code: got %b want %b", i, got_code, e.code); end
      end
      if (e.ev[0]) begin
        checks++; if (got_data !== e.data || seen_addr !== e.maddr) begin
          errors++; $display("FAIL misalign[%0d] data/addr: %h/%h, want %h/%h", i, got_data, seen_addr, e.data, e.maddr); end
      end
    end
  endtask

  task automatic test_illegal;
    exp_t e; logic ld, st; logic [2:0] f3;
    for (int i = 0; i < 5; i++) begin
      e = '{3'b100, 1, 32'h0, 5'd0, ERR_ILLEGAL, 1'b0, 32'h0, 32'h0, 4'h0};
      case (i)
        0: begin ld = 1'b1; st = 1'b0; f3 = 3'b011; end
        1: begin ld = 1'b0; st = 1'b1; f3 = 3'b110; end
        2: begin ld = 1'b1; st = 1'b1; f3 = F3_W; end
        3: begin ld = 1'b0; st = 1'b0; f3 = F3_B; end
        default: begin ld = 1'b1; st = 1'b0; f3 = 3'b111; end
      endcase
      sb_q.push_back(e);
      run_access(ld, st, f3, 32'h400, 32'h0, 5'd2, 1, 1, 32'h0);
      e = sb_q.pop_front();
      checks++; if (ev_seen !== e.ev || ev_cyc != e.cyc || got_code !== e.code) begin
        errors++; $display("FAIL illegal[%0d]: ev=%b cyc=%0d code=%b, want ev=%b cyc=%0d code=%b", i, ev_seen, ev_cyc, got_code, e.ev, e.cyc, e.code); end
      checks++; if (saw_req !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL illegal[%0d] mem_req=%b busy=%b, want 0/0", i, saw_req, busy); end
    end
  endtask

  task automatic test_timeout;
    exp_t e; logic ld; int g, rv, nreq;
    for (int i = 0; i < 4; i++) begin
      e = '{3'b100, 17, 32'h0, 5'd0, ERR_TIMEOUT, 1'b1, 32'h0, 32'h0, 4'h0};
      case (i)
        0: begin ld = 1'b1; g = 20; rv = 1;  nreq = 16; end                 // no grant
        1: begin ld = 1'b1; g = 1;  rv = 30; nreq = 1;  end                 // no rvalid
        2: begin ld = 1'b1; g = 1;  rv = 15; nreq = 1;  e.ev = 3'b001; end  // rvalid on boundary
        default: begin ld = 1'b0; g = 16; rv = 1; nreq = 16; e.ev = 3'b010; end // gnt on boundary
      endcase
      e.data = 32'h0BADF00D;
      sb_q.push_back(e);
      run_access(ld, !ld, F3_W, 32'h500, 32'h0, 5'd4, g, rv, 32'h0BADF00D);
      e = sb_q.pop_front();
      checks++; if (ev_seen !== e.ev || ev_cyc != e.cyc) begin
        errors++; $display("FAIL timeout[%0d] response: ev=%b cyc=%0d, want ev=%b cyc=%0d", i, ev_seen, ev_cyc, e.ev, e.cyc); end
      checks++; if (req_cycles != nreq || got_req !== 1'b0 || unstable !== 1'b0) begin
        errors++; $display("FAIL timeout[%0d] req cycles=%0d req_at_end=%b unstable=%b, want %0d/0/0", i, req_cycles, got_req, unstable, nreq); end
      if (e.ev[2]) begin
        checks++; if (got_code !== e.code) begin
          errors++; $display("FAIL timeout[%0d] err_code: got %b want %b", i, got_code, e.code); end
      end
      if (e.ev[0]) begin
        checks++; if (got_data !== e.data) begin
          errors++; $display("FAIL timeout[%0d] wb_data: got %h want %h", i, got_data, e.data); end
      end
    end
  endtask

  task automatic test_reset_mid_access;
    // load abandoned in WAIT, rvalid arrives after reset
    req_valid = 1'b1; is_load = 1'b1; funct3 = F3_W; addr = 32'h200; rd = 5'd9;
    @(posedge clk); #1;
    req_valid = 1'b0; is_load = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    checks++; if (busy !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL rst-wait setup: busy=%b mem_req=%b, want 1/0", busy, mem_req); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL rst-wait in reset: busy=%b ready=%b, want 0/0", busy, req_ready); end
    reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    checks++; if (wb_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL rst-wait late rvalid: wb_valid=%b ready=%b busy=%b, want 0/1/0", wb_valid, req_ready, busy); end
    // store abandoned in REQ, grant arrives after reset
    req_valid = 1'b1; is_store = 1'b1; funct3 = F3_W; addr = 32'h300; store_data = 32'h1;
    @(posedge clk); #1;
    req_valid = 1'b0; is_store = 1'b0;
    checks++; if (mem_req !== 1'b1) begin
      errors++; $display("FAIL rst-req setup: mem_req=%b want 1", mem_req); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b0) begin
      errors++; $display("FAIL rst-req mem_req after reset: got %b want 0", mem_req); end
    reset = 1'b1; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    checks++; if (st_done !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL rst-req late gnt: st_done=%b busy=%b mem_req=%b, want 0/0/0", st_done, busy, mem_req); end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    e = '{3'b010, 2, 32'h0, 5'd0, 2'b00, 1'b1, 32'h600, 32'h0, 4'h0};
    sb_q.push_back(e);
    e = '{3'b001, 3, 32'hFFFFFF80, 5'd17, 2'b00, 1'b1, 32'h600, 32'h0, 4'h0};
    sb_q.push_back(e);
    run_access(1'b0, 1'b1, F3_W, 32'h600, 32'h13572468, 5'd0, 1, 1, 32'h0);
    e = sb_q.pop_front();
    checks++; if (ev_seen !== e.ev || ev_cyc != e.cyc || rdy_busy !== 1'b0) begin
      errors++; $display("FAIL b2b store: ev=%b cyc=%0d rdy_busy=%b, want %b/%0d/0", ev_seen, ev_cyc, rdy_busy, e.ev, e.cyc); end
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b ready after store: ready=%b busy=%b, want 1/0", req_ready, busy); end
    run_access(1'b1, 1'b0, F3_B, 32'h601, 32'h0, 5'd17, 1, 1, 32'h00008000);
    e = sb_q.pop_front();
    checks++; if (ev_seen !== e.ev || ev_cyc != e.cyc || got_data !== e.data || got_rd !== e.rd) begin
      errors++; $display("FAIL b2b load: ev=%b cyc=%0d data=%h rd=%0d, want %b/%0d/%h/%0d", ev_seen, ev_cyc, got_data, got_rd, e.ev, e.cyc, e.data, e.rd); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_store();
    test_load();
    test_misalign();
    test_illegal();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
